mmcm_ps_ctrl: RTL and testbench



---
 rtl/mmcm_ps_pkg.sv | 21 ++
 rtl/mmcm_ps_ctrl.sv | 153 +++++++++++++++
 tb/tb_mmcm_ps_ctrl.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/mmcm_ps_pkg.sv
// Shared types and helpers for the MMCM fine-phase-shift initiator.
package mmcm_ps_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CHECK = 3'd1,
        ST_PULSE = 3'd2,
        ST_WAIT  = 3'd3,
        ST_GAP   = 3'd4
    } ps_state_t;

    function automatic int clamp_phase(input int value, input int lo, input int hi);
        if (value < lo)
            return lo;
        else if (value > hi)
            return hi;
        else
            return value;
    endfunction

endpackage

// File: rtl/mmcm_ps_ctrl.sv
// Walks the MMCM fine phase one PSEN/PSDONE handshake at a time toward a
// clamped signed target, tracking the current offset and flagging PSDONE faults.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// IDLE     | ready for a new target
// CHECK    | compare target with current offset, latch direction
// PULSE    | PSEN high for one cycle
// WAIT     | wait for PSDONE, bounded by TIMEOUT
// GAP      | settle GAP_CYCLES cycles before the next PSEN
module mmcm_ps_ctrl
    import mmcm_ps_pkg::*;
#(
    parameter int PHASE_W    = 12,
    parameter int PHASE_MIN  = -1024,
    parameter int PHASE_MAX  = 1023,
    parameter int TIMEOUT    = 63,
    parameter int GAP_CYCLES = 2
) (
    input  logic               clk_bufg,
    input  logic               rst_tmp,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [PHASE_W-1:0] cmd_target,
    output logic               PSEN,
    output logic               PSINCDEC,
    input  logic               PSDONE,
    output logic [PHASE_W-1:0] cur_phase,
    output logic               busy,
    output logic               done,
    output logic               err_timeout,
    output logic               err_spurious,
    input  logic               err_clr
);

    localparam int CNT_MAX = (TIMEOUT > GAP_CYCLES) ? TIMEOUT : GAP_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    ps_state_t                  state_q, state_d;
    logic signed [PHASE_W-1:0]  tgt_q, tgt_d;
    logic signed [PHASE_W-1:0]  cur_q, cur_d;
    logic signed [PHASE_W-1:0]  tgt_clamped;
    logic signed [PHASE_W-1:0]  phase_step;
    logic                       incdec_q, incdec_d;
    logic [CNT_W-1:0]           cnt_q, cnt_d;
    logic                       done_d;
    logic                       tout_set;
    logic                       spur_set;

    assign tgt_clamped = PHASE_W'(clamp_phase(int'($signed(cmd_target)), PHASE_MIN, PHASE_MAX));

    // Saturate defensively even though the clamped target keeps us in range.
    always_comb begin
        phase_step = cur_q;
        if (incdec_q) begin
            if (int'(cur_q) < PHASE_MAX)
                phase_step = cur_q + PHASE_W'(1);
        end else begin
            if (int'(cur_q) > PHASE_MIN)
                phase_step = cur_q - PHASE_W'(1);
        end
    end

    always_comb begin
        state_d  = state_q;
        tgt_d    = tgt_q;
        cur_d    = cur_q;
        incdec_d = incdec_q;
        cnt_d    = cnt_q;
        done_d   = 1'b0;
        tout_set = 1'b0;
        spur_set = PSDONE && (state_q != ST_WAIT);

        case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    tgt_d   = tgt_clamped;
                    state_d = ST_CHECK;
                end
            end
            ST_CHECK: begin
                if (tgt_q == cur_q) begin
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    incdec_d = (tgt_q > cur_q);
                    state_d  = ST_PULSE;
                end
            end
            ST_PULSE: begin
                cnt_d   = '0;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (PSDONE) begin
                    cur_d = phase_step;
                    cnt_d = '0;
                    if (phase_step == tgt_q) begin
                        done_d  = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_GAP;
                    end
                end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    tout_set = 1'b1;
                    done_d   = 1'b1;
                    state_d  = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_GAP: begin
                if (cnt_q == CNT_W'(GAP_CYCLES - 1))
                    state_d = ST_PULSE;
                else
                    cnt_d = cnt_q + CNT_W'(1);
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // A fresh error in the same cycle as err_clr must survive the clear.
    always_ff @(posedge clk_bufg or posedge rst_tmp) begin
        if (rst_tmp) begin
            state_q      <= ST_IDLE;
            tgt_q        <= '0;
            cur_q        <= '0;
            incdec_q     <= 1'b0;
            cnt_q        <= '0;
            done         <= 1'b0;
            err_timeout  <= 1'b0;
            err_spurious <= 1'b0;
        end else begin
            state_q      <= state_d;
            tgt_q        <= tgt_d;
            cur_q        <= cur_d;
            incdec_q     <= incdec_d;
            cnt_q        <= cnt_d;
            done         <= done_d;
            err_timeout  <= (err_timeout & ~err_clr) | tout_set;
            err_spurious <= (err_spurious & ~err_clr) | spur_set;
        end
    end

    assign PSEN      = (state_q == ST_PULSE);
    assign PSINCDEC  = incdec_q;
    assign cur_phase = cur_q;
    assign busy      = (state_q != ST_IDLE);
    assign cmd_ready = (state_q == ST_IDLE);

endmodule

// File: tb/tb_mmcm_ps_ctrl.sv
// Scoreboard bench for mmcm_ps_ctrl with a 12-cycle PSDONE responder model.
module tb_mmcm_ps_ctrl;

    localparam int PW = 12;

    logic          clk_bufg   = 1'b0;
    logic          rst_tmp    = 1'b1;
    logic          cmd_valid  = 1'b0;
    logic [PW-1:0] cmd_target = '0;
    logic          PSDONE     = 1'b0;
    logic          err_clr    = 1'b0;
    logic          cmd_ready;
    logic          PSEN;
    logic          PSINCDEC;
    logic [PW-1:0] cur_phase;
    logic          busy;
    logic          done;
    logic          err_timeout;
    logic          err_spurious;

    mmcm_ps_ctrl #(
        .PHASE_W    (PW),
        .PHASE_MIN  (-16),
        .PHASE_MAX  (15),
        .TIMEOUT    (63),
        .GAP_CYCLES (2)
    ) dut (
        .clk_bufg     (clk_bufg),
        .rst_tmp      (rst_tmp),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_target   (cmd_target),
        .PSEN         (PSEN),
        .PSINCDEC     (PSINCDEC),
        .PSDONE       (PSDONE),
        .cur_phase    (cur_phase),
        .busy         (busy),
        .done         (done),
        .err_timeout  (err_timeout),
        .err_spurious (err_spurious),
        .err_clr      (err_clr)
    );

    always #5 clk_bufg = ~clk_bufg;

    int cyc = 0;
    always @(posedge clk_bufg) cyc <= cyc + 1;

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    typedef struct {
        int cyc;
        int phase;
        int tout;
        int spur;
        int pulses;
        int dir;
    } exp_t;

    exp_t sb[$];

    // Responder: PSDONE in the 12th cycle after the PSEN cycle; optional extra
    // pulse one cycle later (lands in the first GAP cycle).
    int resp_cnt   = 0;
    int spur_cnt   = 0;
    bit respond_en = 1'b1;
    bit spur_arm   = 1'b0;

    always @(negedge clk_bufg) begin
        PSDONE = 1'b0;
        if (rst_tmp) begin
            resp_cnt = 0;
            spur_cnt = 0;
        end else begin
            if (resp_cnt > 0) begin
                resp_cnt--;
                if (resp_cnt == 0) PSDONE = 1'b1;
            end
            if (spur_cnt > 0) begin
                spur_cnt--;
                if (spur_cnt == 0) PSDONE = 1'b1;
            end
            if (PSEN && respond_en) resp_cnt = 12;
            if (PSEN && spur_arm) begin
                spur_cnt = 13;
                spur_arm = 1'b0;
            end
        end
    end

    int pulses    = 0;
    int dir_bad   = 0;
    int space_bad = 0;
    int last_psen = 0;

    always @(negedge clk_bufg) begin
        exp_t e;
        if (rst_tmp) begin
            pulses    = 0;
            dir_bad   = 0;
            space_bad = 0;
        end else begin
            if (PSEN) begin
                if (pulses > 0 && (cyc - last_psen) != 15) space_bad++;
                if (sb.size() > 0 && int'(PSINCDEC) != sb[0].dir) dir_bad++;
                last_psen = cyc;
                pulses++;
            end
            if (done) begin
                if (sb.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_done: got done=1 expected no pending command (cycle %0d)", cyc);
                end else begin
                    e = sb.pop_front();
                    chk("done_cycle", cyc, e.cyc);
                    chk("cur_phase", int'($signed(cur_phase)), e.phase);
                    chk("err_timeout", int'(err_timeout), e.tout);
                    chk("err_spurious", int'(err_spurious), e.spur);
                    chk("psen_count", pulses, e.pulses);
                    chk("psincdec", dir_bad, 0);
                    chk("psen_spacing", space_bad, 0);
                end
                pulses    = 0;
                dir_bad   = 0;
                space_bad = 0;
            end
        end
    end

    // lat: cycles from the accept cycle to the done cycle.
    task automatic send(input int tgt, input int lat, input int ph, input int tout,
                        input int spur, input int np, input int dir, input bit push);
        @(negedge clk_bufg);
        cmd_valid  = 1'b1;
        cmd_target = PW'(tgt);
        for (int i = 0; i < 100 && !cmd_ready; i++) @(negedge clk_bufg);
        chk("cmd_ready_accept", int'(cmd_ready), 1);
        if (push) sb.push_back('{cyc: cyc + lat, phase: ph, tout: tout, spur: spur, pulses: np, dir: dir});
        @(negedge clk_bufg);
        cmd_valid = 1'b0;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 600 && sb.size() > 0; i++) @(negedge clk_bufg);
        chk("pending_done", sb.size(), 0);
        sb.delete();
    endtask

    task automatic pulse_clr();
        @(negedge clk_bufg);
        err_clr = 1'b1;
        @(negedge clk_bufg);
        err_clr = 1'b0;
    endtask

    initial begin
        repeat (3) @(negedge clk_bufg);
        rst_tmp = 1'b0;
        @(negedge clk_bufg);
        chk("rst_cmd_ready", int'(cmd_ready), 1);
        chk("rst_busy", int'(busy), 0);
        chk("rst_psen", int'(PSEN), 0);
        chk("rst_psincdec", int'(PSINCDEC), 0);
        chk("rst_cur_phase", int'($signed(cur_phase)), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_err_timeout", int'(err_timeout), 0);
        chk("rst_err_spurious", int'(err_spurious), 0);

        // 0 -> +5: five increments, 15-cycle step period
        send(5, 75, 5, 0, 0, 5, 1, 1);
        wait_idle();
        // +5 -> -3: eight decrements
        send(-3, 120, -3, 0, 0, 8, 0, 1);
        wait_idle();
        // target equals current: done two cycles after accept, no PSEN
        send(-3, 2, -3, 0, 0, 0, 0, 1);
        wait_idle();
        // 2000 clamps to PHASE_MAX=15: 18 increments from -3
        send(2000, 270, 15, 0, 0, 18, 1, 1);
        wait_idle();

        // extra PSDONE during GAP: flagged, phase unaffected
        spur_arm = 1'b1;
        send(13, 30, 13, 0, 1, 2, 0, 1);
        wait_idle();
        pulse_clr();
        chk("spur_cleared", int'(err_spurious), 0);

        // responder silent: timeout 63 WAIT cycles after PSEN
        respond_en = 1'b0;
        send(14, 66, 13, 1, 0, 1, 1, 1);
        wait_idle();
        respond_en = 1'b1;
        chk("tout_phase_hold", int'($signed(cur_phase)), 13);
        pulse_clr();
        chk("tout_cleared", int'(err_timeout), 0);

        // -2000 clamps to PHASE_MIN=-16: 29 decrements from 13
        send(-2000, 435, -16, 0, 0, 29, 0, 1);
        wait_idle();

        // reset in the middle of WAIT
        send(-10, 0, 0, 0, 0, 0, 1, 1'b0);
        for (int i = 0; i < 10 && !PSEN; i++) @(negedge clk_bufg);
        chk("mid_psen_seen", int'(PSEN), 1);
        repeat (3) @(negedge clk_bufg);
        chk("mid_busy", int'(busy), 1);
        chk("mid_cmd_ready", int'(cmd_ready), 0);
        rst_tmp = 1'b1;
        #1;
        chk("arst_psen", int'(PSEN), 0);
        chk("arst_cur_phase", int'($signed(cur_phase)), 0);
        chk("arst_cmd_ready", int'(cmd_ready), 1);
        chk("arst_busy", int'(busy), 0);
        @(negedge clk_bufg);
        rst_tmp = 1'b0;

        // recovery after reset: 0 -> 2
        send(2, 30, 2, 0, 0, 2, 1, 1);
        wait_idle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
